// File: rtl/dkong3_obj_scan_if.sv
// Object record stream from the object-RAM scanner to the sprite line renderer.
// The master drives one record at a time; the slave accepts it with I_OBJ_RDY.
interface dkong3_obj_scan_if;
  logic       O_OBJ_VLD;
  logic       I_OBJ_RDY;
  logic [3:0] O_OBJ_ROW;
  logic [7:0] O_OBJ_CODE;
  logic [7:0] O_OBJ_ATTR;
  logic [7:0] O_OBJ_X;

  modport master (
    output O_OBJ_VLD, O_OBJ_ROW, O_OBJ_CODE, O_OBJ_ATTR, O_OBJ_X,
    input  I_OBJ_RDY
  );

  modport slave (
    input  O_OBJ_VLD, O_OBJ_ROW, O_OBJ_CODE, O_OBJ_ATTR, O_OBJ_X,
    output I_OBJ_RDY
  );
endinterface

// File: rtl/dkong3_obj_scan.sv
// Sprite object RAM (DMA write side) plus a per-line scanner that streams
// every object intersecting the requested line to the renderer.
module dkong3_obj_scan #(
  parameter int unsigned OBJ_COUNT = 104,
  parameter int unsigned MAX_HITS  = 16,
  parameter int unsigned OBJ_H     = 16
) (
  input  logic              I_CLK,
  input  logic              I_RSTn,
  input  logic [9:0]        I_DMA_AD,
  input  logic [7:0]        I_DMA_DD,
  input  logic              I_DMA_CED,
  input  logic              I_DMA_WE,
  input  logic              I_SCAN_START,
  input  logic [7:0]        I_VPOS,
  output logic              O_BUSY,
  output logic              O_DONE,
  output logic              O_OVF,
  output logic [7:0]        O_HIT_CNT,
  dkong3_obj_scan_if.master obj_if
);
  localparam int unsigned     IdxW    = $clog2(OBJ_COUNT);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(OBJ_COUNT - 1);
  localparam logic [7:0]      HitMax  = 8'(MAX_HITS);
  localparam logic [7:0]      ObjH    = 8'(OBJ_H);
  localparam logic [7:0]      RowMask = 8'(OBJ_H - 1);

  typedef enum logic [2:0] {
    StIdle, StRdY, StCmp, StRdC, StRdA, StRdX, StEmit, StFin
  } state_e;

  state_e          r_state, w_state_d;
  logic [IdxW-1:0] r_idx, w_idx_d;
  logic [7:0]      r_vpos, w_vpos_d;
  logic [3:0]      r_row, w_row_d;
  logic [7:0]      r_code, w_code_d;
  logic [7:0]      r_attr, w_attr_d;
  logic [7:0]      r_hit_cnt, w_hit_cnt_d;
  logic            r_ovf, w_ovf_d;
  logic [7:0]      r_rdata;
  logic [7:0]      r_mem [1024];
  logic [1:0]      w_off;
  logic            w_rd_en;
  logic [9:0]      w_rd_addr;
  logic [7:0]      w_diff;
  logic            w_hit;
  logic [7:0]      w_hit_inc;

  // Object RAM: not reset; same-address read/write returns the old byte.
  always_ff @(posedge I_CLK) begin
    if (I_DMA_CED && I_DMA_WE) r_mem[I_DMA_AD] <= I_DMA_DD;
  end

  // Read data only advances in the read states so X stays frozen during EMIT.
  always_ff @(posedge I_CLK) begin
    if (!I_RSTn)      r_rdata <= '0;
    else if (w_rd_en) r_rdata <= r_mem[w_rd_addr];
  end

  always_comb begin
    w_off   = 2'd0;
    w_rd_en = 1'b0;
    unique case (r_state)
      StRdY:   w_rd_en = 1'b1;
      StRdC:   begin w_off = 2'd1; w_rd_en = 1'b1; end
      StRdA:   begin w_off = 2'd2; w_rd_en = 1'b1; end
      StRdX:   begin w_off = 2'd3; w_rd_en = 1'b1; end
      default: ;
    endcase
  end

  assign w_rd_addr = 10'({r_idx, w_off});
  assign w_diff    = r_vpos - r_rdata;
  assign w_hit     = (r_rdata != 8'd0) && (w_diff < ObjH);
  assign w_hit_inc = r_hit_cnt + 8'd1;

  always_comb begin
    w_state_d   = r_state;
    w_idx_d     = r_idx;
    w_vpos_d    = r_vpos;
    w_row_d     = r_row;
    w_code_d    = r_code;
    w_attr_d    = r_attr;
    w_hit_cnt_d = r_hit_cnt;
    w_ovf_d     = r_ovf;
    unique case (r_state)
      StIdle: ;
      StRdY:  w_state_d = StCmp;
      StCmp: begin
        if (w_hit) begin
          w_row_d   = 4'(w_diff & RowMask);
          w_state_d = StRdC;
        end else if (r_idx == LastIdx) begin
          w_state_d = StFin;
        end else begin
          w_idx_d   = r_idx + IdxW'(1);
          w_state_d = StRdY;
        end
      end
      StRdC:  w_state_d = StRdA;
      StRdA: begin
        w_code_d  = r_rdata;
        w_state_d = StRdX;
      end
      StRdX: begin
        w_attr_d  = r_rdata;
        w_state_d = StEmit;
      end
      StEmit: begin
        if (obj_if.I_OBJ_RDY) begin
          w_hit_cnt_d = w_hit_inc;
          if (w_hit_inc == HitMax) begin
            w_ovf_d   = (r_idx != LastIdx);
            w_state_d = StFin;
          end else if (r_idx == LastIdx) begin
            w_state_d = StFin;
          end else begin
            w_idx_d   = r_idx + IdxW'(1);
            w_state_d = StRdY;
          end
        end
      end
      StFin:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    // A start pulse from any state restarts cleanly; an aborted scan never reaches FIN.
    if (I_SCAN_START) begin
      w_state_d   = StRdY;
      w_idx_d     = '0;
      w_vpos_d    = I_VPOS;
      w_hit_cnt_d = '0;
      w_ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RSTn) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_vpos    <= '0;
      r_row     <= '0;
      r_code    <= '0;
      r_attr    <= '0;
      r_hit_cnt <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_idx     <= w_idx_d;
      r_vpos    <= w_vpos_d;
      r_row     <= w_row_d;
      r_code    <= w_code_d;
      r_attr    <= w_attr_d;
      r_hit_cnt <= w_hit_cnt_d;
      r_ovf     <= w_ovf_d;
    end
  end

  assign obj_if.O_OBJ_VLD  = (r_state == StEmit);
  assign obj_if.O_OBJ_ROW  = r_row;
  assign obj_if.O_OBJ_CODE = r_code;
  assign obj_if.O_OBJ_ATTR = r_attr;
  assign obj_if.O_OBJ_X    = r_rdata;
  assign O_BUSY            = (r_state != StIdle);
  assign O_DONE            = (r_state == StFin);
  assign O_OVF             = r_ovf;
  assign O_HIT_CNT         = r_hit_cnt;
endmodule

// File: tb/tb_dkong3_obj_scan.sv
// Bench for dkong3_obj_scan: directed object tables, expected records queued
// at stimulus time and checked by a monitor on every accepted transfer.
module tb_dkong3_obj_scan;
  typedef struct packed {
    logic [3:0] row;
    logic [7:0] code;
    logic [7:0] attr;
    logic [7:0] x;
  } rec_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [9:0] dma_ad;
  logic [7:0] dma_dd;
  logic       dma_ced;
  logic       dma_we;
  logic       scan_start;
  logic [7:0] vpos;
  logic       busy, done, ovf;
  logic [7:0] hit_cnt;

  dkong3_obj_scan_if obj_if ();

  dkong3_obj_scan #(
    .OBJ_COUNT(104),
    .MAX_HITS (16),
    .OBJ_H    (16)
  ) dut (
    .I_CLK       (clk),
    .I_RSTn      (rstn),
    .I_DMA_AD    (dma_ad),
    .I_DMA_DD    (dma_dd),
    .I_DMA_CED   (dma_ced),
    .I_DMA_WE    (dma_we),
    .I_SCAN_START(scan_start),
    .I_VPOS      (vpos),
    .O_BUSY      (busy),
    .O_DONE      (done),
    .O_OVF       (ovf),
    .O_HIT_CNT   (hit_cnt),
    .obj_if      (obj_if)
  );

  initial forever #5 clk = ~clk;

  int   checks    = 0;
  int   failures  = 0;
  int   done_cnt  = 0;
  int   stall_len = 0;
  int   stall_cnt = 0;
  int   scan_d0   = 0;
  rec_t exp_q[$];
  logic l_vld = 1'b0;
  logic l_rdy = 1'b0;
  rec_t l_rec;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor + renderer model: pops on each transfer seen at the previous edge.
  always @(negedge clk) begin
    rec_t cur;
    rec_t e;
    cur = '{obj_if.O_OBJ_ROW, obj_if.O_OBJ_CODE, obj_if.O_OBJ_ATTR, obj_if.O_OBJ_X};
    if (l_vld && l_rdy) begin
      if (exp_q.size() == 0) begin
        chk("rec_unexpected", int'(l_rec), -1);
      end else begin
        e = exp_q.pop_front();
        chk("rec_row", int'(l_rec.row), int'(e.row));
        chk("rec_code", int'(l_rec.code), int'(e.code));
        chk("rec_attr", int'(l_rec.attr), int'(e.attr));
        chk("rec_x", int'(l_rec.x), int'(e.x));
      end
    end else if (l_vld && obj_if.O_OBJ_VLD) begin
      chk("rec_stable", int'(cur), int'(l_rec));
    end
    if (!obj_if.O_OBJ_VLD) begin
      stall_cnt        = 0;
      obj_if.I_OBJ_RDY = (stall_len == 0);
    end else if (!obj_if.I_OBJ_RDY) begin
      stall_cnt++;
      if (stall_cnt >= stall_len) obj_if.I_OBJ_RDY = 1'b1;
    end
    l_vld = obj_if.O_OBJ_VLD;
    l_rdy = obj_if.I_OBJ_RDY;
    l_rec = cur;
    if (done) done_cnt++;
  end

  task automatic dma_raw(input logic [9:0] a, input logic [7:0] d, input logic ce,
                         input logic we);
    dma_ad  = a;
    dma_dd  = d;
    dma_ced = ce;
    dma_we  = we;
    @(negedge clk);
    dma_ced = 1'b0;
    dma_we  = 1'b0;
  endtask

  task automatic put_obj(input int idx, input logic [7:0] y, input logic [7:0] c,
                         input logic [7:0] a, input logic [7:0] x);
    dma_raw(10'(4 * idx), y, 1'b1, 1'b1);
    dma_raw(10'(4 * idx + 1), c, 1'b1, 1'b1);
    dma_raw(10'(4 * idx + 2), a, 1'b1, 1'b1);
    dma_raw(10'(4 * idx + 3), x, 1'b1, 1'b1);
  endtask

  task automatic clear_tab();
    for (int i = 0; i < 104; i++) dma_raw(10'(4 * i), 8'h00, 1'b1, 1'b1);
  endtask

  task automatic push_exp(input logic [3:0] r, input logic [7:0] c, input logic [7:0] a,
                          input logic [7:0] x);
    exp_q.push_back('{r, c, a, x});
  endtask

  // Returns at the negedge following the start edge (first scan cycle).
  task automatic start_scan(input string nm, input logic [7:0] v, input int post_stall);
    scan_d0    = done_cnt;
    vpos       = v;
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    stall_len  = post_stall;
    chk({nm, "_busy_on"}, int'(busy), 1);
    chk({nm, "_vld_low"}, int'(obj_if.O_OBJ_VLD), 0);
  endtask

  task automatic finish_scan(input string nm, input int cyc0, input int exp_cnt,
                             input int exp_ovf, input int exp_cyc);
    int cyc;
    bit seen;
    cyc  = cyc0;
    seen = 1'b0;
    while (!seen && cyc < 3000) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk({nm, "_done_seen"}, int'(seen), 1);
    if (exp_cyc > 0) chk({nm, "_cycles"}, cyc, exp_cyc);
    @(negedge clk);
    chk({nm, "_done_1cyc"}, int'(done), 0);
    chk({nm, "_busy_off"}, int'(busy), 0);
    chk({nm, "_hit_cnt"}, int'(hit_cnt), exp_cnt);
    chk({nm, "_ovf"}, int'(ovf), exp_ovf);
    chk({nm, "_done_cnt"}, done_cnt - scan_d0, 1);
    chk({nm, "_recs_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_scan(input string nm, input logic [7:0] v, input int post_stall,
                          input int exp_cnt, input int exp_ovf, input int exp_cyc);
    start_scan(nm, v, post_stall);
    finish_scan(nm, 1, exp_cnt, exp_ovf, exp_cyc);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_vld"}, int'(obj_if.O_OBJ_VLD), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
    chk({nm, "_ovf"}, int'(ovf), 0);
    chk({nm, "_hit_cnt"}, int'(hit_cnt), 0);
    chk({nm, "_row"}, int'(obj_if.O_OBJ_ROW), 0);
    chk({nm, "_code"}, int'(obj_if.O_OBJ_CODE), 0);
    chk({nm, "_attr"}, int'(obj_if.O_OBJ_ATTR), 0);
    chk({nm, "_x"}, int'(obj_if.O_OBJ_X), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int d0;
    int n;
    rstn       = 1'b0;
    dma_ad     = '0;
    dma_dd     = '0;
    dma_ced    = 1'b0;
    dma_we     = 1'b0;
    scan_start = 1'b0;
    vpos       = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // 1. Empty table timing, then a single hit; gated DMA writes must not land.
    clear_tab();
    run_scan("empty", 8'h45, 0, 0, 0, 209);
    put_obj(0, 8'h40, 8'h12, 8'h05, 8'h80);
    dma_raw(10'(4 * 7), 8'h44, 1'b0, 1'b1);
    dma_raw(10'(4 * 8), 8'h44, 1'b1, 1'b0);
    push_exp(4'h5, 8'h12, 8'h05, 8'h80);
    run_scan("single", 8'h45, 0, 1, 0, 213);

    // 2. Wraparound hit and the OBJ_H boundary.
    clear_tab();
    put_obj(0, 8'hF8, 8'h21, 8'h02, 8'h33);
    push_exp(4'hF, 8'h21, 8'h02, 8'h33);
    run_scan("wrap", 8'h07, 0, 1, 0, -1);
    put_obj(0, 8'h40, 8'h22, 8'h03, 8'h34);
    run_scan("diff16", 8'h50, 0, 0, 0, -1);
    push_exp(4'hF, 8'h22, 8'h03, 8'h34);
    run_scan("diff15", 8'h4F, 0, 1, 0, -1);
    run_scan("diffneg", 8'h3F, 0, 0, 0, -1);

    // 3. Backpressure on three hits.
    clear_tab();
    put_obj(5, 8'h60, 8'h31, 8'h01, 8'h41);
    put_obj(30, 8'h5A, 8'h32, 8'h02, 8'h42);
    put_obj(77, 8'h63, 8'h33, 8'h03, 8'h43);
    push_exp(4'h3, 8'h31, 8'h01, 8'h41);
    push_exp(4'h9, 8'h32, 8'h02, 8'h42);
    push_exp(4'h0, 8'h33, 8'h03, 8'h43);
    run_scan("stall", 8'h63, 10, 3, 0, -1);

    // 4. Hit limit with entries left, and exactly at the last entry.
    clear_tab();
    for (int i = 0; i < 20; i++) put_obj(i, 8'h10, 8'(i), 8'(8'h40 + i), 8'(8'h80 + i));
    for (int i = 0; i < 16; i++) push_exp(4'h0, 8'(i), 8'(8'h40 + i), 8'(8'h80 + i));
    run_scan("ovf", 8'h10, 0, 16, 1, 97);
    clear_tab();
    for (int i = 88; i < 104; i++) put_obj(i, 8'h10, 8'(i), 8'(i + 1), 8'(i + 2));
    for (int i = 88; i < 104; i++) push_exp(4'h0, 8'(i), 8'(i + 1), 8'(i + 2));
    run_scan("limit_last", 8'h10, 0, 16, 0, 273);

    // 5. Restart during a stalled EMIT.
    clear_tab();
    put_obj(2, 8'h10, 8'hA1, 8'h11, 8'h21);
    put_obj(3, 8'h20, 8'hB1, 8'h12, 8'h22);
    put_obj(6, 8'h1C, 8'hC1, 8'h13, 8'h23);
    d0 = done_cnt;
    start_scan("first", 8'h10, 100000);
    n = 0;
    while (!obj_if.O_OBJ_VLD && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("first_vld_seen", int'(obj_if.O_OBJ_VLD), 1);
    repeat (3) @(negedge clk);
    push_exp(4'h0, 8'hB1, 8'h12, 8'h22);
    push_exp(4'h4, 8'hC1, 8'h13, 8'h23);
    run_scan("restart", 8'h20, 0, 2, 0, -1);
    chk("restart_total_done", done_cnt - d0, 1);

    // 6a. Reset after the first accepted record, then rescan the retained RAM.
    d0 = done_cnt;
    push_exp(4'h0, 8'hB1, 8'h12, 8'h22);
    start_scan("prerst", 8'h20, 0);
    n = 0;
    while (hit_cnt != 8'd1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("prerst_hit1", int'(hit_cnt), 1);
    rstn = 1'b0;
    @(negedge clk);
    chk_all_zero("midrst");
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_recs_left", exp_q.size(), 0);
    exp_q.delete();
    push_exp(4'h0, 8'hB1, 8'h12, 8'h22);
    push_exp(4'h4, 8'hC1, 8'h13, 8'h23);
    run_scan("rescan", 8'h20, 0, 2, 0, -1);

    // 6b. DMA lands entry 50 while the scanner is around entry 10.
    clear_tab();
    put_obj(5, 8'h30, 8'h55, 8'h01, 8'h66);
    push_exp(4'h0, 8'h55, 8'h01, 8'h66);
    push_exp(4'h2, 8'h77, 8'h08, 8'h99);
    start_scan("concur", 8'h30, 0);
    repeat (24) @(negedge clk);
    put_obj(50, 8'h2E, 8'h77, 8'h08, 8'h99);
    finish_scan("concur", 29, 2, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
